// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the GPR write port, with a pending-write
// scoreboard that the issue stage uses to stall on RAW hazards.
module regfile_wb_arbiter #(
  parameter int N    = 32,
  parameter int REQS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQS-1:0]   req_valid,
  input  logic [5*REQS-1:0] req_addr,
  input  logic [N*REQS-1:0] req_data,
  output logic [REQS-1:0]   req_ready,
  input  logic              issue_valid,
  input  logic [4:0]        issue_addr,
  output logic [4:0]        write_addr,
  output logic [N-1:0]      write_data,
  output logic              write_enable,
  output logic [31:0]       busy
);

  localparam int PW  = $clog2(REQS);
  localparam int PW1 = PW + 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] gidx;
  logic [PW:0]   idx;
  logic          found;
  logic [REQS-1:0] grant;
  logic [4:0]    gaddr;
  logic [N-1:0]  gdata;
  logic          gwrite;
  logic [31:0]   busy_d;

  // Rotating scan starting at ptr; first valid requester wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < REQS; k++) begin
      idx = {1'b0, ptr} + PW1'(k);
      if (idx >= PW1'(REQS)) idx = idx - PW1'(REQS);
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        gidx  = idx[PW-1:0];
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign req_ready = grant & {REQS{rst_n}};
  assign gaddr     = req_addr[int'(gidx)*5 +: 5];
  assign gdata     = req_data[int'(gidx)*N +: N];
  assign gwrite    = found && (gaddr != 5'd0);
  assign ptr_nxt   = (gidx == PW'(REQS-1)) ? '0 : gidx + 1'b1;

  // Set after clear so a fresh issue to the retiring register stays busy.
  always_comb begin
    busy_d = busy;
    if (write_enable) busy_d[write_addr] = 1'b0;
    if (issue_valid && issue_addr != 5'd0) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      busy         <= '0;
    end else begin
      write_enable <= gwrite;
      if (gwrite) begin
        write_addr <= gaddr;
        write_data <= gdata;
      end
      if (found) ptr <= ptr_nxt;
      busy <= busy_d;
    end
  end

  no_reissue_to_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(issue_valid && issue_addr != 5'd0 && busy[issue_addr] &&
      !(write_enable && write_addr == issue_addr))
  );

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback arbiter and pending-write scoreboard for the 32-entry GPR file.
- Shares the file's single write port between REQS writeback sources (ALU, load unit, CSR unit), granting one per cycle round-robin.
- Drives write_addr/write_data/write_enable from a registered stage.
- Tracks which GPRs have an issued-but-unwritten result, so the issue stage can stall on RAW hazards.

Parameters:
N, 32, data width of the GPRs and write port.
REQS, 3, number of writeback requesters (2..8).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  REQS  requester i has a writeback pending.
req_addr  input  5*REQS  destination register of requester i, packed at bits [5i+4:5i].
req_data  input  N*REQS  result of requester i, packed at bits [Ni+N-1:Ni].
req_ready  output  REQS  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
issue_valid  input  1  issue stage dispatches an instruction that writes a GPR.
issue_addr  input  5  destination register of the dispatched instruction.
write_addr  output  5  regfile write address.
write_data  output  N  regfile write data.
write_enable  output  1  regfile write strobe.
busy  output  32  bit r high means GPR r has a pending write.

Behaviour:
- Reset, asynchronous on rst_n low:
  - write_enable=0, write_addr=0, write_data=0.
  - busy=0, round-robin pointer=0.
  - All in-flight writebacks are discarded. There is no recovery mid-operation.
- Arbitration is combinational within the cycle:
  - req_ready is one-hot or zero.
  - Scan starts at pointer p and proceeds p, p+1, ..., REQS-1, 0, ..., p-1. The first i with req_valid[i] high is granted.
  - req_ready is 0 while rst_n is low.
- Pointer update: after a grant to i, p <= (i+1) mod REQS. With no grant, p holds.
- Requester rules:
  - A requester must hold valid/addr/data stable until it is granted.
  - The arbiter must not depend on valid being dropped without a grant.
- Latency:
  - An accepted transfer (i, addr A, data D) in cycle t produces write_enable=1, write_addr=A, write_data=D in cycle t+1.
  - The regfile writes at the edge ending t+1.
  - Throughput is one write per cycle. The output stage never stalls.
- With no grant in cycle t, write_enable=0 in t+1. write_addr and write_data hold their previous values.
- x0 rule:
  - A grant with addr 0 is accepted (ready=1) but produces write_enable=0 in t+1.
  - issue_addr=0 never sets busy. busy[0] is always 0.
- Scoreboard:
  - busy[issue_addr] is set at the edge following a cycle where issue_valid=1.
  - busy[write_addr] is cleared at the edge ending a cycle where write_enable=1.
  - Simultaneous set and clear of the same r: set wins, because a newer write is pending.
  - Set and clear on different registers both take effect.
  - A clear of a non-busy register is a no-op.
  - The scoreboard counts only one outstanding write per register. The issue stage must not re-issue to a busy register; this is asserted in simulation only.
- busy reflects registered state, with no same-cycle bypass of issue or clear. Readers rely on the regfile's own write-to-read forwarding for the t+1 write.
- Widths: addresses are 5 bits unsigned. Packed slices follow the indexing given under Ports.

Test Plan:
1. Reset mid-stream: hold req_valid=3'b111 and busy nonzero, pulse rst_n low -> same cycle: busy=0, write_enable=0, req_ready=0. After release, first grant goes to requester 0.
2. Round-robin fairness: req_valid=3'b111 held with distinct addrs 5, 6, 7 (requesters are not deasserted) -> grants cycle 0, 1, 2, 0, ... Write_addr sequence 5, 6, 7, 5 with 1-cycle lag.
3. Pointer skip: p=1, req_valid=3'b101 -> grant requester 2, next p=0. Next cycle with req_valid=3'b001 -> grant requester 0.
4. x0 suppression: requester 1 sends addr 0, data 32'hDEADBEEF -> req_ready[1]=1, next-cycle write_enable=0. issue_addr=0 with issue_valid=1 -> busy stays 0.
5. Scoreboard lifecycle:
   - issue_addr=9 -> busy[9]=1 next cycle.
   - Requester 0 writes addr 9, data 32'h12345678 -> write_enable=1, write_addr=9 one cycle later; busy[9]=0 the cycle after.
6. Set/clear collision: write_enable=1 with write_addr=12 in the same cycle as issue_valid=1, issue_addr=12 -> busy[12] remains 1. Simultaneous issue to 3 with a clear of 4 -> busy[3]=1, busy[4]=0.
